// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-address width and the pipeline control word.
package hazard_ctrl_pkg;

   localparam int REG_W = 6;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
   } ctrl_t;

   // All enables low; the bubble/flush bits are then raised on top of this.
   localparam ctrl_t CTRL_NOP   = '0;
   localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
   localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
   localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Two-source / one-destination register match. Register 0 is not special.
module hazard_cmp
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs_i,
   input  logic [REG_W-1:0] rt_i,
   input  logic             use_rs_i,
   input  logic             use_rt_i,
   input  logic [REG_W-1:0] rd_i,
   input  logic             reg_write_i,
   output logic             hit_o
);

   assign hit_o = reg_write_i & ((use_rs_i & (rs_i == rd_i)) |
                                 (use_rt_i & (rt_i == rd_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage pipeline without forwarding, with
// saturating debug counters for stalled cycles and taken-branch flushes.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regWrite,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_regWrite,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]       FCNT_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [1:0]       scnt_q, scnt_d;
   logic [1:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hz_ex, hz_wb;
   logic             stall_inc, flush_inc;
   ctrl_t            ctrl;

   hazard_cmp u_cmp_ex (
      .rs_i(id_rs), .rt_i(id_rt), .use_rs_i(id_use_rs), .use_rt_i(id_use_rt),
      .rd_i(ex_rd), .reg_write_i(ex_regWrite), .hit_o(hz_ex)
   );

   hazard_cmp u_cmp_wb (
      .rs_i(id_rs), .rt_i(id_rt), .use_rs_i(id_use_rs), .use_rt_i(id_use_rt),
      .rd_i(wb_rd), .reg_write_i(wb_regWrite), .hit_o(hz_wb)
   );

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      fcnt_d    = fcnt_q;
      ctrl      = CTRL_NOP;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (ex_branch_taken) begin
               ctrl      = CTRL_FLUSH;
               flush_inc = 1'b1;
               // With a single squash cycle this RUN cycle does all the work.
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
                  fcnt_d  = FCNT_INIT;
               end
            end else if (hz_ex) begin
               ctrl      = CTRL_STALL;
               stall_inc = 1'b1;
               state_d   = ST_STALL;
               scnt_d    = 2'd1;
            end else if (hz_wb) begin
               ctrl      = CTRL_STALL;
               stall_inc = 1'b1;
            end else begin
               ctrl = CTRL_RUN;
            end
         end
         ST_STALL: begin
            ctrl      = CTRL_STALL;
            stall_inc = 1'b1;
            if (scnt_q <= 2'd1) begin
               state_d = ST_RUN;
               scnt_d  = 2'd0;
            end else begin
               scnt_d = scnt_q - 2'd1;
            end
         end
         ST_FLUSH: begin
            ctrl = CTRL_FLUSH;
            if (fcnt_q <= 2'd1) begin
               state_d = ST_RUN;
               fcnt_d  = 2'd0;
            end else begin
               fcnt_d = fcnt_q - 2'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         scnt_q      <= 2'd0;
         fcnt_q      <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_write    = ctrl.pc_write;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_bubble = ctrl.idex_bubble;
   assign state       = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random stimulus for hazard_ctrl checked against a
// cycle-budget model (remaining stall/flush cycles plus event counts).
module tb_hazard_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 4;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset;
   logic [5:0]       id_rs, id_rt, ex_rd, wb_rd;
   logic             id_use_rs, id_use_rt, ex_regWrite, wb_regWrite, ex_branch_taken;
   logic             pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycles of forced stall/flush still owed, and event counts.
   int m_stall_left = 0;
   int m_flush_left = 0;
   int m_stalls     = 0;
   int m_flushes    = 0;

   hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
      .ex_branch_taken(ex_branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v < CNT_MAX) ? v + 1 : CNT_MAX;
   endfunction

   // One clock cycle: drive, check combinational/registered outputs, advance model.
   task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                       input int exrd, input bit exw, input int wbrd, input bit wbw,
                       input bit br, input bit rst);
      bit hex, hwb;
      int kind;      // 0 run, 1 stall, 2 squash
      int exp_state;
      @(negedge clock);
      id_rs = 6'(rs); id_rt = 6'(rt); id_use_rs = urs; id_use_rt = urt;
      ex_rd = 6'(exrd); ex_regWrite = exw; wb_rd = 6'(wbrd); wb_regWrite = wbw;
      ex_branch_taken = br; reset = rst;
      #2;
      hex = exw && ((urs && rs == exrd) || (urt && rt == exrd));
      hwb = wbw && ((urs && rs == wbrd) || (urt && rt == wbrd));
      if (m_stall_left > 0)      begin kind = 1; exp_state = 1; end
      else if (m_flush_left > 0) begin kind = 2; exp_state = 2; end
      else begin
         exp_state = 0;
         if (br)               kind = 2;
         else if (hex || hwb)  kind = 1;
         else                  kind = 0;
      end
      chk("pc_write",    pc_write,    kind != 1);
      chk("ifid_write",  ifid_write,  kind != 1);
      chk("ifid_flush",  ifid_flush,  kind == 2);
      chk("idex_bubble", idex_bubble, kind != 0);
      chk("state",       state,       exp_state);
      chk("stall_cnt",   stall_cnt,   m_stalls);
      chk("flush_cnt",   flush_cnt,   m_flushes);
      if (rst) begin
         m_stall_left = 0; m_flush_left = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_stall_left > 0) begin
         m_stall_left--;
         m_stalls = sat_inc(m_stalls);
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (br) begin
         m_flush_left = FLUSH_CYCLES - 1;
         m_flushes    = sat_inc(m_flushes);
      end else if (hex) begin
         m_stall_left = 1;
         m_stalls     = sat_inc(m_stalls);
      end else if (hwb) begin
         m_stalls = sat_inc(m_stalls);
      end
   endtask

   task automatic idle(input bit rst);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
   endtask

   initial begin
      reset = 1'b1;
      id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
      ex_rd = '0; ex_regWrite = 0; wb_rd = '0; wb_regWrite = 0; ex_branch_taken = 0;
      repeat (2) @(posedge clock);

      // Reset values with all inputs low.
      idle(1);
      idle(0);

      // Load-use through EX: two bubbles, RUN->STALL->RUN.
      step(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      step(5, 0, 1, 0, 0, 0, 5, 1, 0, 0);
      idle(0);
      chk("ex_load_use_stalls", stall_cnt, 2);

      // WB-only hazard on rt: one bubble, state stays RUN.
      idle(1);
      step(0, 9, 0, 1, 4, 1, 9, 1, 0, 0);
      idle(0);
      chk("wb_only_stalls", stall_cnt, 1);

      // Taken branch: two squashed cycles, then a branch colliding with hz_ex.
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(7, 0, 1, 0, 7, 1, 0, 0, 1, 0);
      idle(0);
      chk("branch_flushes", flush_cnt, 1);
      step(2, 0, 1, 0, 2, 1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("branch_beats_hz_ex", stall_cnt, 0);

      // Register read not used: no stall. Register 0 still hazards.
      step(3, 0, 0, 0, 3, 1, 3, 1, 0, 0);
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // Reset during the second stall cycle.
      idle(1);
      step(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      step(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);
      idle(0);

      // Saturation: 20 WB stalls on a 4-bit counter.
      idle(1);
      repeat (20) step(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
      idle(0);
      chk("stall_saturates", stall_cnt, 15);

      // Random traffic on a small register set so matches are frequent.
      idle(1);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
